spraid_n: RTL and testbench
===========================

SPRAID_N -- requirements
Module: spraid_n

Interface
REQ-001 Parameter NUM_DRIVES, default 4: number of attached drive channels; legal range 3..8.
REQ-002 Parameter DATA_W, default 8: drive data width in bits.
REQ-003 Parameter ADDR_W, default 16: drive address width in bits.
REQ-004 Parameter TIMEOUT_CYC, default 4096: maximum cycles spent waiting on drive busy per phase.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 raid_type  input  4  mode code: 0 = RAID1 mirror, 1 = RAID0 stripe, 5 = RAID5 rotating parity.
REQ-008 req_valid / req_ready  input / output  1 each  host request handshake.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  32  logical byte address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_rdata  output  DATA_W  read data, valid with rsp_valid.
REQ-014 rsp_err  output  1  error flag, valid with rsp_valid.
REQ-015 drv_read / drv_write  output  NUM_DRIVES  per-drive one-cycle command strobes.
REQ-016 drv_addr  output  ADDR_W  shared drive address.
REQ-017 drv_wdata  output  NUM_DRIVES*DATA_W  flattened per-drive write data; drive i occupies slice i.
REQ-018 drv_rdata  input  NUM_DRIVES*DATA_W  flattened per-drive read data.
REQ-019 drv_busy  input  NUM_DRIVES  per-drive busy.

Function
REQ-020 A request SHALL be accepted when req_valid && req_ready; req_ready SHALL be high only in IDLE.
REQ-021 raid_type, req_addr, req_write and req_wdata SHALL be captured at acceptance; later changes SHALL NOT affect the request in flight.
REQ-022 FSM states SHALL be: IDLE, ISSUE, WAIT, RMW_CALC, DONE; DONE returns to IDLE the next cycle.
REQ-023 ISSUE SHALL pulse the strobe for every selected drive for exactly one cycle; WAIT SHALL skip one cycle, then wait until every selected drive has drv_busy low.
REQ-024 RAID0 addressing SHALL be: drive = addr % N, drv_addr = addr / N.
REQ-025 RAID1 writes SHALL target all drives with identical data; RAID1 reads SHALL read all drives, return drive 0 data, and set rsp_err if any drive's data differs.
REQ-026 RAID5 addressing SHALL be: row = addr / (N-1), parity drive p = row % N, slot k = addr % (N-1), data drive = (k < p) ? k : k+1, drv_addr = row.
REQ-027 A RAID5 write SHALL read the old data and old parity, compute new parity = old_p ^ old_d ^ new_d in RMW_CALC, then write data and parity in one ISSUE.
REQ-028 A RAID5 read SHALL read only the data drive, except as defined in REQ-037.
REQ-029 drv_addr SHALL be truncated to ADDR_W bits, with no error raised.
REQ-030 An unsupported raid_type SHALL complete in DONE with rsp_err=1, issuing no drive strobes.
REQ-031 If WAIT exceeds TIMEOUT_CYC cycles, the FSM SHALL go to DONE with rsp_err=1 and issue no further strobes.
REQ-032 Total latency SHALL be: acceptance to rsp_valid = 3 cycles plus drive busy time per phase, plus 1 cycle for RMW_CALC.

Reset
REQ-033 Reset assertion SHALL immediately force IDLE and drive all strobes, rsp_valid and rsp_err to 0 and rsp_rdata to 0; req_ready SHALL be 1 after reset release.
REQ-034 Reset asserted mid-operation SHALL abandon the request with no response pulse.

Configuration
REQ-035 The macro SPRAID_PARITY_CHECK_EN SHALL control RAID5 read parity verification.
REQ-036 With SPRAID_PARITY_CHECK_EN undefined, RAID5 reads SHALL behave as in REQ-028.
REQ-037 With SPRAID_PARITY_CHECK_EN defined, a RAID5 read SHALL read all N drives of the row and set rsp_err if their XOR is nonzero; data SHALL still be returned.

Structure
REQ-038 A shared package spraid_pkg SHALL hold the raid_type codes, the FSM state enum and the address-map function.
REQ-039 Address mapping SHALL be one sub-module, spraid_map, that is combinational and maps (addr, mode) to (drive mask, parity drive, drv_addr).

Verification (N=4, DATA_W=8)
REQ-040 RAID0 write addr=6, data 0xA5 -> only drv_write[2] pulses, drv_addr=1, drv_wdata slice2=0xA5.
REQ-041 RAID1 read with drives returning 0x11,0x11,0x12,0x11 -> rsp_rdata=0x11, rsp_err=1.
REQ-042 RAID5 write addr=5, new 0x0F, old data 0x30, old parity 0x03 -> reads drives 3 and 1 at drv_addr 1; writes 0x0F to drive 3 and 0x3C to drive 1.
REQ-043 Drive 2 busy held high for 5000 cycles -> rsp_valid with rsp_err=1 after TIMEOUT_CYC cycles.
REQ-044 raid_type=7 -> no strobes; rsp_valid with rsp_err=1 three cycles after acceptance.
REQ-045 Reset asserted in WAIT -> strobes low, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/spraid_pkg.sv
// ============================================================================
// Module      : spraid_pkg
// Description : Shared RAID mode codes, controller state encoding and the
//               logical-to-physical address map function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spraid_pkg;

  localparam logic [3:0] c_raid1 = 4'd0;
  localparam logic [3:0] c_raid0 = 4'd1;
  localparam logic [3:0] c_raid5 = 4'd5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT     = 3'd2,
    RMW_CALC = 3'd3,
    DONE     = 3'd4
  } state_t;

  typedef struct packed {
    logic        ok;
    logic [7:0]  mask;
    logic [2:0]  data_drv;
    logic [2:0]  par_drv;
    logic [31:0] daddr;
  } map_t;

  // Unsupported modes leave ok=0 and an empty mask, so nothing gets strobed.
  function automatic map_t map_addr(input logic [31:0] addr, input logic [3:0] mode,
                                    input int unsigned n);
    map_t        m;
    logic [31:0] row;
    logic [31:0] slot;
    logic [31:0] par;
    m = '0;
    row = '0;
    slot = '0;
    par = '0;
    case (mode)
      c_raid0: begin
        m.ok       = 1'b1;
        m.data_drv = 3'(addr % n);
        m.mask     = 8'(1) << m.data_drv;
        m.daddr    = addr / n;
      end
      c_raid1: begin
        m.ok    = 1'b1;
        m.daddr = addr;
        for (int unsigned i = 0; i < 8; i++) begin
          if (i < n) m.mask[i] = 1'b1;
        end
      end
      c_raid5: begin
        row        = addr / (n - 1);
        slot       = addr % (n - 1);
        par        = row % n;
        m.ok       = 1'b1;
        m.par_drv  = 3'(par);
        m.data_drv = (slot < par) ? 3'(slot) : 3'(slot + 1);
        m.mask     = (8'(1) << m.data_drv) | (8'(1) << m.par_drv);
        m.daddr    = row;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spraid_map.sv
// ============================================================================
// Module      : spraid_map
// Description : Combinational address map from (addr, mode) to drive mask,
//               data/parity drive indices and the shared drive address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spraid_map
  import spraid_pkg::*;
#(
  parameter int NUM_DRIVES = 4,
  parameter int ADDR_W     = 16
) (
  input  logic [31:0]           addr,
  input  logic [3:0]            mode,
  output logic                  mode_ok,
  output logic [NUM_DRIVES-1:0] drive_mask,
  output logic [2:0]            data_drv,
  output logic [2:0]            parity_drv,
  output logic [ADDR_W-1:0]     drv_addr
);

  map_t w_map;
  logic w_unused_map;

  assign w_map      = map_addr(addr, mode, 32'(NUM_DRIVES));
  assign mode_ok    = w_map.ok;
  assign drive_mask = w_map.mask[NUM_DRIVES-1:0];
  assign data_drv   = w_map.data_drv;
  assign parity_drv = w_map.par_drv;
  // Upper address bits are dropped silently; the drive address space wraps.
  assign drv_addr   = w_map.daddr[ADDR_W-1:0];
  assign w_unused_map = ^w_map;

endmodule

`default_nettype wire

// File: rtl/spraid_n.sv
// ============================================================================
// Module      : spraid_n
// Description : N-drive RAID0/1/5 controller with read-modify-write parity.
//               Optional macro SPRAID_PARITY_CHECK_EN: RAID5 reads fetch the
//               whole row and flag a nonzero XOR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spraid_n
  import spraid_pkg::*;
#(
  parameter int NUM_DRIVES  = 4,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   raid_type,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [31:0]                  req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_DRIVES-1:0]        drv_read,
  output logic [NUM_DRIVES-1:0]        drv_write,
  output logic [ADDR_W-1:0]            drv_addr,
  output logic [NUM_DRIVES*DATA_W-1:0] drv_wdata,
  input  logic [NUM_DRIVES*DATA_W-1:0] drv_rdata,
  input  logic [NUM_DRIVES-1:0]        drv_busy
);

  localparam int                 c_cnt_w   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYC);

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_mode;
  logic [31:0]           r_addr;
  logic                  r_write;
  logic                  r_phase_wr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_old_d;
  logic [DATA_W-1:0]     r_old_p;
  logic [DATA_W-1:0]     r_parity;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic [c_cnt_w-1:0]    r_cnt;

  logic                  w_map_ok;
  logic [NUM_DRIVES-1:0] w_map_mask;
  logic [2:0]            w_data_drv;
  logic [2:0]            w_par_drv;
  logic [NUM_DRIVES-1:0] w_sel;
  logic                  w_wait_done;
  logic                  w_timeout;
  logic                  w_rmw;
  logic [DATA_W-1:0]     w_slice;
  logic [DATA_W-1:0]     w_rd_d;
  logic [DATA_W-1:0]     w_rd_p;
  logic                  w_mismatch;
`ifdef SPRAID_PARITY_CHECK_EN
  logic [DATA_W-1:0]     w_xor;
`endif

  spraid_map #(
    .NUM_DRIVES(NUM_DRIVES),
    .ADDR_W    (ADDR_W)
  ) u_map (
    .addr      (r_addr),
    .mode      (r_mode),
    .mode_ok   (w_map_ok),
    .drive_mask(w_map_mask),
    .data_drv  (w_data_drv),
    .parity_drv(w_par_drv),
    .drv_addr  (drv_addr)
  );

  // RAID5 reads touch only the data drive unless the whole row is verified.
  always_comb begin
    w_sel = w_map_mask;
    if (r_mode == c_raid5 && !r_write) begin
`ifdef SPRAID_PARITY_CHECK_EN
      w_sel = '1;
`else
      w_sel = NUM_DRIVES'(1) << w_data_drv;
`endif
    end
  end

  always_comb begin
    w_slice    = '0;
    w_rd_d     = '0;
    w_rd_p     = '0;
    w_mismatch = 1'b0;
`ifdef SPRAID_PARITY_CHECK_EN
    w_xor      = '0;
`endif
    for (int i = 0; i < NUM_DRIVES; i++) begin
      w_slice = drv_rdata[i*DATA_W +: DATA_W];
      if (3'(i) == w_data_drv) w_rd_d = w_slice;
      if (3'(i) == w_par_drv) w_rd_p = w_slice;
      if (w_slice != drv_rdata[DATA_W-1:0]) w_mismatch = 1'b1;
`ifdef SPRAID_PARITY_CHECK_EN
      w_xor = w_xor ^ w_slice;
`endif
    end
  end

  for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_wdata
    assign drv_wdata[i*DATA_W +: DATA_W] =
        (r_mode == c_raid5 && 3'(i) == w_par_drv) ? r_parity : r_wdata;
  end

  assign w_rmw = (r_mode == c_raid5) && r_write && !r_phase_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    drv_read     = '0;
    drv_write    = '0;
    w_wait_done  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = ISSUE;
      end
      ISSUE: begin
        if (r_phase_wr) drv_write = w_sel;
        else            drv_read  = w_sel;
        w_state_next = WAIT;
      end
      WAIT: begin
        // First WAIT cycle gives the drives time to raise busy.
        if (r_cnt != '0 && (drv_busy & w_sel) == '0) begin
          w_wait_done  = 1'b1;
          w_state_next = w_rmw ? RMW_CALC : DONE;
        end else if (r_cnt >= c_timeout) begin
          w_timeout    = 1'b1;
          w_state_next = DONE;
        end
      end
      RMW_CALC: w_state_next = ISSUE;
      DONE: begin
        rsp_valid    = 1'b1;
        rsp_err      = r_err;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode     <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_phase_wr <= 1'b0;
      r_wdata    <= '0;
      r_old_d    <= '0;
      r_old_p    <= '0;
      r_parity   <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_mode     <= raid_type;
            r_addr     <= req_addr;
            r_write    <= req_write;
            r_wdata    <= req_wdata;
            r_phase_wr <= req_write && (raid_type != c_raid5);
            r_rdata    <= '0;
            r_err      <= 1'b0;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_wait_done) begin
            if (!w_map_ok) begin
              r_err <= 1'b1;
            end else if (!r_phase_wr) begin
              r_old_d <= w_rd_d;
              r_old_p <= w_rd_p;
              if (!r_write) r_rdata <= w_rd_d;
              if (r_mode == c_raid1 && w_mismatch) r_err <= 1'b1;
`ifdef SPRAID_PARITY_CHECK_EN
              if (r_mode == c_raid5 && !r_write && w_xor != '0) r_err <= 1'b1;
`endif
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        RMW_CALC: begin
          r_parity   <= r_old_p ^ r_old_d ^ r_wdata;
          r_phase_wr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_spraid_n.sv
// ============================================================================
// Module      : tb_spraid_n
// Description : Directed self-checking bench for spraid_n (N=4, DATA_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spraid_n;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int TO = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    raid_type = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [N-1:0]  drv_read;
  logic [N-1:0]  drv_write;
  logic [AW-1:0] drv_addr;
  logic [N*DW-1:0] drv_wdata;
  logic [N*DW-1:0] drv_rdata = '0;
  logic [N-1:0]  drv_busy = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;

  int            rd_cnt, wr_cnt, rsp_cnt, rsp_cyc;
  logic [N-1:0]  rd_mask, wr_mask;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [DW-1:0] rsp_data;
  logic          rsp_e;

  spraid_n #(.NUM_DRIVES(N), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .raid_type(raid_type), .req_valid(req_valid),
    .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .drv_read(drv_read), .drv_write(drv_write),
    .drv_addr(drv_addr), .drv_wdata(drv_wdata), .drv_rdata(drv_rdata),
    .drv_busy(drv_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: records the last strobe of each kind and the response.
  always @(negedge clk) begin
    if (drv_read != '0) begin rd_cnt++; rd_mask = drv_read; rd_addr = drv_addr; end
    if (drv_write != '0) begin
      wr_cnt++; wr_mask = drv_write; wr_addr = drv_addr; wr_data = drv_wdata;
    end
    if (rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; rsp_data = rsp_rdata; rsp_e = rsp_err; end
  end

  task automatic clr_mon();
    rd_cnt = 0; wr_cnt = 0; rsp_cnt = 0; rsp_cyc = 0;
    rd_mask = '0; wr_mask = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    rsp_data = '0; rsp_e = 1'b0;
  endtask

  // Present one request for a single edge, then scramble the request inputs.
  task automatic send(input logic [3:0] m, input logic w, input logic [31:0] a,
                      input logic [DW-1:0] d);
    clr_mon();
    @(negedge clk);
    raid_type = m; req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0; raid_type = 4'd7; req_write = ~w; req_addr = 32'hFFFF_FFFF;
    req_wdata = ~d;
  endtask

  task automatic wait_rsp(input int maxc);
    for (int i = 0; i < maxc && rsp_cnt == 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if ({drv_read, drv_write} !== '0) begin failures++; $display("FAIL reset_strobes got %h want 0", {drv_read, drv_write}); end
    checks++; if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rdata_err got %h/%b want 00/0", rsp_rdata, rsp_err); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_raid0_write();
    send(4'd1, 1'b1, 32'd6, 8'hA5);
    wait_rsp(20);
    checks++; if (wr_mask !== 4'b0100 || wr_cnt !== 1) begin failures++; $display("FAIL r0w_mask got %b x%0d want 0100 x1", wr_mask, wr_cnt); end
    checks++; if (wr_addr !== 16'd1) begin failures++; $display("FAIL r0w_addr got %h want 0001", wr_addr); end
    checks++; if (wr_data[23:16] !== 8'hA5) begin failures++; $display("FAIL r0w_data got %h want a5", wr_data[23:16]); end
    checks++; if (rd_cnt !== 0) begin failures++; $display("FAIL r0w_noread got %0d want 0", rd_cnt); end
    checks++; if (rsp_cnt !== 1 || rsp_e !== 1'b0) begin failures++; $display("FAIL r0w_rsp got %0d/%b want 1/0", rsp_cnt, rsp_e); end
    checks++; if (rsp_cyc - acc_cyc !== 3) begin failures++; $display("FAIL r0w_latency got %0d want 3", rsp_cyc - acc_cyc); end
  endtask

  task automatic test_raid0_read();
    drv_rdata = 32'h5A33_2211;
    send(4'd1, 1'b0, 32'd7, 8'h00);
    wait_rsp(20);
    checks++; if (rd_mask !== 4'b1000 || rd_addr !== 16'd1) begin failures++; $display("FAIL r0r_map got %b@%h want 1000@0001", rd_mask, rd_addr); end
    checks++; if (rsp_data !== 8'h5A || rsp_e !== 1'b0) begin failures++; $display("FAIL r0r_data got %h/%b want 5a/0", rsp_data, rsp_e); end
    // Drive address wraps at ADDR_W bits without error.
    send(4'd1, 1'b1, 32'h0004_0008, 8'h3E);
    wait_rsp(20);
    checks++; if (wr_mask !== 4'b0001 || wr_addr !== 16'h0002) begin failures++; $display("FAIL r0_trunc got %b@%h want 0001@0002", wr_mask, wr_addr); end
    checks++; if (rsp_cnt !== 1 || rsp_e !== 1'b0) begin failures++; $display("FAIL r0_trunc_err got %0d/%b want 1/0", rsp_cnt, rsp_e); end
  endtask

  task automatic test_raid1();
    drv_rdata = 32'h1112_1111;
    send(4'd0, 1'b0, 32'd9, 8'h00);
    wait_rsp(20);
    checks++; if (rd_mask !== 4'b1111 || rd_addr !== 16'd9) begin failures++; $display("FAIL r1r_map got %b@%h want 1111@0009", rd_mask, rd_addr); end
    checks++; if (rsp_data !== 8'h11 || rsp_e !== 1'b1) begin failures++; $display("FAIL r1r_mismatch got %h/%b want 11/1", rsp_data, rsp_e); end
    drv_rdata = 32'h4444_4444;
    send(4'd0, 1'b0, 32'd9, 8'h00);
    wait_rsp(20);
    checks++; if (rsp_data !== 8'h44 || rsp_e !== 1'b0) begin failures++; $display("FAIL r1r_match got %h/%b want 44/0", rsp_data, rsp_e); end
    send(4'd0, 1'b1, 32'h123, 8'h77);
    wait_rsp(20);
    checks++; if (wr_mask !== 4'b1111 || wr_addr !== 16'h0123) begin failures++; $display("FAIL r1w_map got %b@%h want 1111@0123", wr_mask, wr_addr); end
    checks++; if (wr_data !== 32'h7777_7777) begin failures++; $display("FAIL r1w_data got %h want 77777777", wr_data); end
  endtask

  task automatic test_raid5_write();
    drv_rdata = 32'h3000_0300;
    send(4'd5, 1'b1, 32'd5, 8'h0F);
    wait_rsp(30);
    checks++; if (rd_mask !== 4'b1010 || rd_addr !== 16'd1 || rd_cnt !== 1) begin failures++; $display("FAIL r5w_read got %b@%h x%0d want 1010@0001 x1", rd_mask, rd_addr, rd_cnt); end
    checks++; if (wr_mask !== 4'b1010 || wr_addr !== 16'd1 || wr_cnt !== 1) begin failures++; $display("FAIL r5w_write got %b@%h x%0d want 1010@0001 x1", wr_mask, wr_addr, wr_cnt); end
    checks++; if (wr_data[31:24] !== 8'h0F) begin failures++; $display("FAIL r5w_data got %h want 0f", wr_data[31:24]); end
    checks++; if (wr_data[15:8] !== 8'h3C) begin failures++; $display("FAIL r5w_parity got %h want 3c", wr_data[15:8]); end
    checks++; if (rsp_cnt !== 1 || rsp_e !== 1'b0) begin failures++; $display("FAIL r5w_rsp got %0d/%b want 1/0", rsp_cnt, rsp_e); end
  endtask

  task automatic test_raid5_read();
    logic [N-1:0] exp_mask;
    logic         exp_err;
`ifdef SPRAID_PARITY_CHECK_EN
    exp_mask = 4'b1111; exp_err = 1'b1;
`else
    exp_mask = 4'b1000; exp_err = 1'b0;
`endif
    drv_rdata = 32'h0F02_3C01;
    send(4'd5, 1'b0, 32'd5, 8'h00);
    wait_rsp(20);
    checks++; if (rd_mask !== exp_mask || rd_addr !== 16'd1) begin failures++; $display("FAIL r5r_map got %b@%h want %b@0001", rd_mask, rd_addr, exp_mask); end
    checks++; if (rsp_data !== 8'h0F || rsp_e !== exp_err) begin failures++; $display("FAIL r5r_data got %h/%b want 0f/%b", rsp_data, rsp_e, exp_err); end
    checks++; if (wr_cnt !== 0) begin failures++; $display("FAIL r5r_nowrite got %0d want 0", wr_cnt); end
  endtask

  task automatic test_timeout();
    int lat;
    drv_busy = 4'b0100;
    send(4'd1, 1'b1, 32'd2, 8'h55);
    wait_rsp(TO + 100);
    lat = rsp_cyc - acc_cyc;
    checks++; if (rsp_cnt !== 1 || rsp_e !== 1'b1) begin failures++; $display("FAIL timeout_rsp got %0d/%b want 1/1", rsp_cnt, rsp_e); end
    checks++; if (lat < TO || lat > TO + 8) begin failures++; $display("FAIL timeout_latency got %0d want %0d..%0d", lat, TO, TO + 8); end
    while (cyc - acc_cyc < 5000) @(posedge clk);
    drv_busy = '0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (wr_cnt !== 1 || rd_cnt !== 0 || rsp_cnt !== 1) begin failures++; $display("FAIL timeout_quiet got w%0d r%0d rsp%0d want w1 r0 rsp1", wr_cnt, rd_cnt, rsp_cnt); end
  endtask

  task automatic test_bad_mode();
    send(4'd7, 1'b1, 32'd3, 8'h99);
    wait_rsp(20);
    checks++; if (rd_cnt !== 0 || wr_cnt !== 0) begin failures++; $display("FAIL bad_strobes got r%0d w%0d want 0 0", rd_cnt, wr_cnt); end
    checks++; if (rsp_cnt !== 1 || rsp_e !== 1'b1) begin failures++; $display("FAIL bad_rsp got %0d/%b want 1/1", rsp_cnt, rsp_e); end
    checks++; if (rsp_cyc - acc_cyc !== 3) begin failures++; $display("FAIL bad_latency got %0d want 3", rsp_cyc - acc_cyc); end
  endtask

  task automatic test_reset_mid();
    drv_busy = 4'b0010;
    send(4'd1, 1'b0, 32'd1, 8'h00);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({drv_read, drv_write} !== '0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_outputs got %h/%b want 0/0", {drv_read, drv_write}, rsp_valid); end
    drv_busy = '0;
    @(negedge clk); reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rsp_cnt !== 0) begin failures++; $display("FAIL rstmid_norsp got %0d want 0", rsp_cnt); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got %b want 1", req_ready); end
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_raid0_write();
    test_raid0_read();
    test_raid1();
    test_raid5_write();
    test_raid5_read();
    test_bad_mode();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
